// File: rtl/led_pwm_sequencer_if.sv
// Control inputs and LED-side outputs of the LED PWM sequencer, bundled for the
// peripheral selector (master) and the sequencer itself (slave).
interface led_pwm_sequencer_if #(
    parameter int NUM_CH = 2,
    parameter int LED_W  = 8
);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                    enable;
    logic [1:0]              mode;
    logic [NUM_CH*LED_W-1:0] led_out;
    logic [IDX_W-1:0]        active_idx;
    logic                    step_pulse;

    modport master (
        output enable,
        output mode,
        input  led_out,
        input  active_idx,
        input  step_pulse
    );

    modport slave (
        input  enable,
        input  mode,
        output led_out,
        output active_idx,
        output step_pulse
    );
endinterface

// File: rtl/led_pwm_sequencer.sv
// Multi-bank LED PWM sequencer: rotating hot channel, static and breathing fade
// modes over a shared free-running PWM counter and a fixed step interval.
module led_pwm_sequencer #(
    parameter int NUM_CH     = 2,
    parameter int LED_W      = 8,
    parameter int PWM_BITS   = 20,
    parameter int STEP_TICKS = 50000000,
    parameter int DUTY_HI    = 943718,
    parameter int DUTY_LO    = 52429,
    parameter int FADE_STEP  = 65536
) (
    input logic                clk,
    input logic                rst_n,
    led_pwm_sequencer_if.slave bus
);
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TICK_W = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
    localparam int W1     = PWM_BITS + 1;

    localparam logic [PWM_BITS-1:0] HI           = PWM_BITS'(DUTY_HI);
    localparam logic [PWM_BITS-1:0] LO           = PWM_BITS'(DUTY_LO);
    localparam logic [PWM_BITS-1:0] FADE_N       = PWM_BITS'(FADE_STEP);
    localparam logic [W1-1:0]       FADE_W1      = W1'(FADE_STEP);
    localparam logic [W1-1:0]       HI_W1        = W1'(DUTY_HI);
    localparam logic [W1-1:0]       LO_PLUS_STEP = W1'(DUTY_LO + FADE_STEP);

    typedef enum logic [1:0] {
        MODE_ROTATE  = 2'd0,
        MODE_STATIC  = 2'd1,
        MODE_BREATHE = 2'd2,
        MODE_DARK    = 2'd3
    } mode_e;

    mode_e                   mode_q;
    logic [PWM_BITS-1:0]     pwm_cnt;
    logic [TICK_W-1:0]       tick_cnt;
    logic [PWM_BITS-1:0]     fade_lvl;
    logic                    fade_up;
    logic [IDX_W-1:0]        active_q;
    logic                    step_q;
    logic [NUM_CH*LED_W-1:0] led_q;

    logic                    clear;
    logic                    step_now;
    logic [W1-1:0]           fade_sum;
    logic [PWM_BITS-1:0]     fade_next;
    logic                    fade_up_next;
    logic [PWM_BITS-1:0]     duty;
    logic [NUM_CH*LED_W-1:0] led_next;

    assign clear    = !bus.enable || (mode_e'(bus.mode) != mode_q);
    assign step_now = (tick_cnt == TICK_W'(STEP_TICKS - 1));

    // Breathe level is saturated at both ends; the sum is one bit wider so it cannot wrap.
    always_comb begin
        fade_sum     = {1'b0, fade_lvl} + FADE_W1;
        fade_next    = fade_lvl;
        fade_up_next = fade_up;
        if (fade_up) begin
            if (fade_sum >= HI_W1) begin
                fade_next    = HI;
                fade_up_next = 1'b0;
            end else begin
                fade_next = fade_sum[PWM_BITS-1:0];
            end
        end else begin
            if ({1'b0, fade_lvl} <= LO_PLUS_STEP) begin
                fade_next    = LO;
                fade_up_next = 1'b1;
            end else begin
                fade_next = fade_lvl - FADE_N;
            end
        end
    end

    // Strict compare so a zero duty (including the dark mode) is fully off.
    always_comb begin
        led_next = '0;
        duty     = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            case (mode_q)
                MODE_ROTATE:  duty = (IDX_W'(ch) == active_q) ? HI : LO;
                MODE_STATIC:  duty = HI;
                MODE_BREATHE: duty = fade_lvl;
                default:      duty = '0;
            endcase
            if (pwm_cnt < duty) begin
                led_next[ch*LED_W +: LED_W] = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_ROTATE;
            pwm_cnt  <= '0;
            tick_cnt <= '0;
            fade_lvl <= LO;
            fade_up  <= 1'b1;
            active_q <= '0;
            step_q   <= 1'b0;
            led_q    <= '0;
        end else if (clear) begin
            mode_q   <= mode_e'(bus.mode);
            pwm_cnt  <= '0;
            tick_cnt <= '0;
            fade_lvl <= LO;
            fade_up  <= 1'b1;
            active_q <= '0;
            step_q   <= 1'b0;
            led_q    <= '0;
        end else begin
            pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
            tick_cnt <= step_now ? '0 : tick_cnt + TICK_W'(1);
            step_q   <= step_now;
            led_q    <= led_next;
            if (step_now && mode_q == MODE_ROTATE) begin
                active_q <= (active_q == IDX_W'(NUM_CH - 1)) ? '0 : active_q + IDX_W'(1);
            end
            if (step_now && mode_q == MODE_BREATHE) begin
                fade_lvl <= fade_next;
                fade_up  <= fade_up_next;
            end
        end
    end

    assign bus.led_out    = led_q;
    assign bus.active_idx = active_q;
    assign bus.step_pulse = step_q;
endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Scoreboard bench for led_pwm_sequencer: stimulus queues per-step expectations
// (hot index and per-bank on-cycle counts), a negedge monitor checks them.
module tb_led_pwm_sequencer;
    localparam int NUM_CH     = 3;
    localparam int LED_W      = 4;
    localparam int PWM_BITS   = 4;
    localparam int STEP_TICKS = 8;
    localparam int DUTY_HI    = 12;
    localparam int DUTY_LO    = 2;
    localparam int FADE_STEP  = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    led_pwm_sequencer_if #(.NUM_CH(NUM_CH), .LED_W(LED_W)) bus ();

    led_pwm_sequencer #(
        .NUM_CH(NUM_CH), .LED_W(LED_W), .PWM_BITS(PWM_BITS), .STEP_TICKS(STEP_TICKS),
        .DUTY_HI(DUTY_HI), .DUTY_LO(DUTY_LO), .FADE_STEP(FADE_STEP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int idx;
        int c0;
        int c1;
        int c2;
    } step_exp_t;

    step_exp_t exp_q [$];
    int errors = 0;
    int checks = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic expect_step(input int idx, input int c0, input int c1, input int c2);
        exp_q.push_back('{idx, c0, c1, c2});
    endtask

    task automatic apply_stimulus(input logic en, input logic [1:0] md, input int cycles);
        bus.enable = en;
        bus.mode   = md;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    // A window runs from just after a clear (or reset) up to and including the step sample.
    int        acc [NUM_CH];
    logic      clear_edge = 1'b0;
    logic [1:0] last_mode = 2'd0;
    step_exp_t e;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int ch = 0; ch < NUM_CH; ch++) acc[ch] = 0;
            clear_edge = !bus.enable || (bus.mode != 2'd0);
            last_mode  = bus.mode;
        end else begin
            if (clear_edge) begin
                check_output("clear led_out", int'(bus.led_out), 0);
                check_output("clear active_idx", int'(bus.active_idx), 0);
                check_output("clear step_pulse", int'(bus.step_pulse), 0);
                for (int ch = 0; ch < NUM_CH; ch++) acc[ch] = 0;
            end else begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (bus.led_out[ch*LED_W +: LED_W] == {LED_W{1'b1}}) acc[ch]++;
                end
                if (bus.step_pulse) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected step_pulse", int'(bus.step_pulse), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_output("step active_idx", int'(bus.active_idx), e.idx);
                        check_output("window on-count bank0", acc[0], e.c0);
                        check_output("window on-count bank1", acc[1], e.c1);
                        check_output("window on-count bank2", acc[2], e.c2);
                    end
                    for (int ch = 0; ch < NUM_CH; ch++) acc[ch] = 0;
                end
            end
            clear_edge = !bus.enable || (bus.mode != last_mode);
            last_mode  = bus.mode;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.enable = 1'b1;
        bus.mode   = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #3 rst_n = 1'b1;

        // Rotate run out of reset, then an asynchronous reset mid-window.
        expect_step(1, 8, 2, 2);
        expect_step(2, 0, 4, 0);
        apply_stimulus(1'b1, 2'd0, 20);
        rst_n = 1'b0;
        #1;
        check_output("async reset led_out", int'(bus.led_out), 0);
        check_output("async reset active_idx", int'(bus.active_idx), 0);
        check_output("async reset step_pulse", int'(bus.step_pulse), 0);
        bus.enable = 1'b0;
        @(negedge clk);
        #3 rst_n = 1'b1;
        apply_stimulus(1'b0, 2'd0, 40);

        // Rotate: hot bank moves 0->1->2->0->1->2.
        expect_step(1, 8, 2, 2);
        expect_step(2, 0, 4, 0);
        expect_step(0, 2, 2, 8);
        expect_step(1, 4, 0, 0);
        expect_step(2, 2, 8, 2);
        apply_stimulus(1'b1, 2'd0, 40);

        // Switch to breathe with active_idx at 2; levels 2,7,12,7,2,7,12.
        expect_step(0, 2, 2, 2);
        expect_step(0, 0, 0, 0);
        expect_step(0, 8, 8, 8);
        expect_step(0, 0, 0, 0);
        expect_step(0, 2, 2, 2);
        expect_step(0, 0, 0, 0);
        expect_step(0, 8, 8, 8);
        apply_stimulus(1'b1, 2'd2, 57);

        // Static for three steps, then enable drops exactly on the fourth step.
        expect_step(0, 8, 8, 8);
        expect_step(0, 4, 4, 4);
        expect_step(0, 8, 8, 8);
        apply_stimulus(1'b1, 2'd1, 32);
        apply_stimulus(1'b0, 2'd1, 5);

        // Reserved mode: dark banks but steps keep coming.
        expect_step(0, 0, 0, 0);
        expect_step(0, 0, 0, 0);
        expect_step(0, 0, 0, 0);
        apply_stimulus(1'b1, 2'd3, 28);
        apply_stimulus(1'b0, 2'd3, 3);

        check_output("pending expected steps", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
